// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared types and constants for the matrix memory front end.
//   packer_state_t    : frame packer FSM states
//   SYNC_BYTE_DEFAULT : default frame start marker
//   MATRIX_MEM_WIDTH  : width of one matrix memory word
// -----------------------------------------------------------------------------
package matrix_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2,
    FLUSH   = 2'd3
  } packer_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         MATRIX_MEM_WIDTH  = 32;

endpackage

// File: rtl/stream_timeout_timer.sv
// -----------------------------------------------------------------------------
// stream_timeout_timer
// Counts idle cycles between received bytes. While enabled and not cleared it
// counts up; when the count sits at TIMEOUT_CYCLES-1 on a cycle with no clear,
// expired pulses for one cycle and the counter restarts from zero.
// Ports:
//   data_clk : clock (rising edge)
//   rst_n    : synchronous, active-low reset
//   clear    : restart the count (a byte was accepted)
//   enable   : count only while the owning FSM waits on the stream
//   expired  : one-cycle timeout pulse
// -----------------------------------------------------------------------------
module stream_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic data_clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;
  logic          w_expired;

  assign w_expired = enable && !clear && (r_count == LAST);
  assign expired   = w_expired;

  always_ff @(posedge data_clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples the pre-edge values of its neighbours.
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear || !enable || w_expired) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/matrix_stream_packer.sv
// -----------------------------------------------------------------------------
// matrix_stream_packer
// Finds SYNC_BYTE in the host byte stream, packs the following payload bytes
// little-endian into 32-bit words and emits exactly A+B words per frame. A
// trailing XOR checksum byte is verified; a frame that stalls is padded with
// zero words so downstream address counters stay aligned.
// Ports:
//   data_clk   : clock (rising edge)
//   rst_n      : synchronous, active-low reset
//   rx_valid   : rx_byte valid this cycle
//   rx_byte    : received byte
//   data_valid : one-cycle pulse, data holds a complete word
//   data       : packed word, holds its value between pulses
//   frame_done : one-cycle pulse, frame complete with matching checksum
//   frame_err  : one-cycle pulse, checksum mismatch or timeout abort
//   busy       : high whenever the packer is not in IDLE
// -----------------------------------------------------------------------------
module matrix_stream_packer
  import matrix_pkg::*;
#(
  parameter int         MATRIX_A_MEM_DEPTH = 64,
  parameter int         MATRIX_B_MEM_DEPTH = 64,
  parameter logic [7:0] SYNC_BYTE          = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES     = 100000
) (
  input  logic                        data_clk,
  input  logic                        rst_n,
  input  logic                        rx_valid,
  input  logic [7:0]                  rx_byte,
  output logic                        data_valid,
  output logic [MATRIX_MEM_WIDTH-1:0] data,
  output logic                        frame_done,
  output logic                        frame_err,
  output logic                        busy
);

  localparam int             TOTAL_WORDS = MATRIX_A_MEM_DEPTH + MATRIX_B_MEM_DEPTH;
  localparam int             WCW         = $clog2(TOTAL_WORDS + 1);
  localparam logic [WCW-1:0] LAST_WORD   = WCW'(TOTAL_WORDS - 1);
  localparam int             LW          = MATRIX_MEM_WIDTH - 8;

  // Registered state and outputs
  packer_state_t               r_state;
  logic [1:0]                  r_byte_idx;
  logic [WCW-1:0]              r_word_cnt;
  logic [7:0]                  r_csum;
  logic [LW-1:0]               r_lanes;      // lanes 0..2 of the word in progress
  logic [MATRIX_MEM_WIDTH-1:0] r_data;
  logic                        r_data_valid;
  logic                        r_frame_done;
  logic                        r_frame_err;
  logic                        r_busy;

  // Next-state values
  packer_state_t               w_state_nxt;
  logic [1:0]                  w_byte_idx_nxt;
  logic [WCW-1:0]              w_word_cnt_nxt;
  logic [7:0]                  w_csum_nxt;
  logic [LW-1:0]               w_lanes_nxt;
  logic [MATRIX_MEM_WIDTH-1:0] w_data_nxt;
  logic                        w_data_valid_nxt;
  logic                        w_frame_done_nxt;
  logic                        w_frame_err_nxt;
  logic                        w_busy_nxt;

  logic w_timer_en;
  logic w_expired;

  // The timer only runs while waiting on the stream; any accepted byte restarts it.
  assign w_timer_en = (r_state == PAYLOAD) || (r_state == CHECK);

  stream_timeout_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .data_clk (data_clk),
    .rst_n    (rst_n),
    .clear    (rx_valid),
    .enable   (w_timer_en),
    .expired  (w_expired)
  );

  always_comb begin
    // NOTE: every value assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt      = r_state;
    w_byte_idx_nxt   = r_byte_idx;
    w_word_cnt_nxt   = r_word_cnt;
    w_csum_nxt       = r_csum;
    w_lanes_nxt      = r_lanes;
    w_data_nxt       = r_data;
    w_data_valid_nxt = 1'b0;
    w_frame_done_nxt = 1'b0;
    w_frame_err_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        if (rx_valid && (rx_byte == SYNC_BYTE)) begin
          w_state_nxt    = PAYLOAD;
          w_byte_idx_nxt = 2'd0;
          w_word_cnt_nxt = '0;
          w_csum_nxt     = 8'h00;
          w_lanes_nxt    = '0;
        end
      end

      PAYLOAD: begin
        if (rx_valid) begin
          w_csum_nxt     = r_csum ^ rx_byte;
          w_byte_idx_nxt = r_byte_idx + 2'd1;
          case (r_byte_idx)
            2'd0: w_lanes_nxt[7:0]   = rx_byte;
            2'd1: w_lanes_nxt[15:8]  = rx_byte;
            2'd2: w_lanes_nxt[23:16] = rx_byte;
            default: begin
              w_data_nxt       = {rx_byte, r_lanes};
              w_data_valid_nxt = 1'b1;
              w_lanes_nxt      = '0;
              w_word_cnt_nxt   = r_word_cnt + WCW'(1);
              if (r_word_cnt == LAST_WORD) begin
                w_state_nxt = CHECK;
              end
            end
          endcase
        end else if (w_expired) begin
          w_state_nxt = FLUSH;
        end
      end

      CHECK: begin
        if (rx_valid) begin
          w_frame_done_nxt = (rx_byte == r_csum);
          w_frame_err_nxt  = (rx_byte != r_csum);
          w_state_nxt      = IDLE;
        end else if (w_expired) begin
          w_frame_err_nxt = 1'b1;
          w_state_nxt     = IDLE;
        end
      end

      FLUSH: begin
        // Unwritten lanes are always zero, so the first flush word is the
        // zero-extended partial word and every later one is all zeros.
        w_data_nxt       = {8'h00, r_lanes};
        w_data_valid_nxt = 1'b1;
        w_lanes_nxt      = '0;
        w_byte_idx_nxt   = 2'd0;
        w_word_cnt_nxt   = r_word_cnt + WCW'(1);
        if (r_word_cnt == LAST_WORD) begin
          w_frame_err_nxt = 1'b1;
          w_state_nxt     = IDLE;
        end
      end

      default: w_state_nxt = IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge data_clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_byte_idx   <= 2'd0;
      r_word_cnt   <= '0;
      r_csum       <= 8'h00;
      r_lanes      <= '0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_byte_idx   <= w_byte_idx_nxt;
      r_word_cnt   <= w_word_cnt_nxt;
      r_csum       <= w_csum_nxt;
      r_lanes      <= w_lanes_nxt;
      r_data       <= w_data_nxt;
      r_data_valid <= w_data_valid_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_frame_err  <= w_frame_err_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  assign data_valid = r_data_valid;
  assign data       = r_data;
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;
  assign busy       = r_busy;

endmodule

// File: tb/tb_matrix_stream_packer.sv
// -----------------------------------------------------------------------------
// tb_matrix_stream_packer
// Directed sequence with randomized payloads and gaps for matrix_stream_packer
// (A=2, B=2, TIMEOUT_CYCLES=8). Expected words, checksums and pulse positions
// are computed from the frame contents with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_matrix_stream_packer;

  localparam int         A     = 2;
  localparam int         B     = 2;
  localparam int         T     = 8;
  localparam int         TOTAL = A + B;
  localparam int         NPL   = 4 * TOTAL;
  localparam logic [7:0] SYNC  = 8'hA5;

  logic        data_clk = 1'b0;
  logic        rst_n    = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte  = 8'h00;
  logic        data_valid;
  logic [31:0] data;
  logic        frame_done;
  logic        frame_err;
  logic        busy;

  int          checks    = 0;
  int          errors    = 0;
  int          cyc       = 0;
  logic [31:0] last_word = 32'h0;
  logic [7:0]  pl [0:NPL-1];

  matrix_stream_packer #(
    .MATRIX_A_MEM_DEPTH (A),
    .MATRIX_B_MEM_DEPTH (B),
    .SYNC_BYTE          (SYNC),
    .TIMEOUT_CYCLES     (T)
  ) dut (
    .data_clk   (data_clk),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .data_valid (data_valid),
    .data       (data),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 data_clk = ~data_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge data_clk);
    #1;
    cyc++;
  endtask

  task automatic check_quiet(input string tag);
    check1({tag, "_dv"},   data_valid, 1'b0);
    check1({tag, "_done"}, frame_done, 1'b0);
    check1({tag, "_err"},  frame_err,  1'b0);
    check ({tag, "_hold"}, data,       last_word);
  endtask

  task automatic idle(input int n, input logic exp_busy);
    for (int k = 0; k < n; k++) begin
      rx_valid = 1'b0;
      tick();
      check_quiet("idle");
      check1("idle_busy", busy, exp_busy);
    end
  endtask

  task automatic push(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  function automatic logic [7:0] xor_all();
    logic [7:0] x = 8'h00;
    for (int k = 0; k < NPL; k++) x ^= pl[k];
    return x;
  endfunction

  // Sync plus the first n payload bytes, with random gaps up to max_gap.
  task automatic send_payload(input int n, input int max_gap, input bit chk_spacing);
    int prev_dv;
    logic [31:0] w;
    push(SYNC);
    cyc     = 1;
    prev_dv = 0;
    check_quiet("sync");
    check1("sync_busy", busy, 1'b1);
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(max_gap, 0), 1'b1);
      push(pl[i]);
      check1("pl_busy", busy, 1'b1);
      if ((i % 4) == 3) begin
        w = {pl[i], pl[i-1], pl[i-2], pl[i-3]};
        check1("word_dv", data_valid, 1'b1);
        check ("word_data", data, w);
        check1("word_done", frame_done, 1'b0);
        check1("word_err", frame_err, 1'b0);
        last_word = w;
        if (chk_spacing && i >= 7) check("dv_spacing", cyc - prev_dv, 4);
        prev_dv = cyc;
      end else begin
        check_quiet("pl");
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] csum_byte, input int max_gap, input bit b2b);
    logic [7:0] x;
    x = xor_all();
    send_payload(NPL, max_gap, b2b);
    idle($urandom_range(max_gap, 0), 1'b1);
    push(csum_byte);
    check1("csum_done", frame_done, csum_byte == x);
    check1("csum_err",  frame_err,  csum_byte != x);
    check1("csum_dv",   data_valid, 1'b0);
    check1("csum_busy", busy,       1'b0);
    if (b2b) check("done_cycle", cyc, 18);
    idle(2, 1'b0);
  endtask

  task automatic rand_payload();
    for (int k = 0; k < NPL; k++) pl[k] = 8'($urandom);
  endtask

  initial begin
    // Reset
    rst_n = 1'b0;
    tick();
    tick();
    check1("rst_dv",   data_valid, 1'b0);
    check ("rst_data", data,       32'h0);
    check1("rst_done", frame_done, 1'b0);
    check1("rst_err",  frame_err,  1'b0);
    check1("rst_busy", busy,       1'b0);
    rst_n = 1'b1;
    idle(2, 1'b0);

    // Noise before sync is dropped
    push(8'h00); check_quiet("noise0"); check1("noise0_busy", busy, 1'b0);
    push(8'hFF); check_quiet("noise1"); check1("noise1_busy", busy, 1'b0);
    push(8'h5A); check_quiet("noise2"); check1("noise2_busy", busy, 1'b0);

    // Directed frame 0x01..0x10, checksum 0x10 then 0x00
    for (int k = 0; k < NPL; k++) pl[k] = 8'(k + 1);
    send_frame(8'h10, 1, 1'b0);
    send_frame(8'h00, 1, 1'b0);

    // Random payloads with an embedded sync byte; good and bad checksums
    rand_payload();
    pl[5] = SYNC;
    send_frame(xor_all(), 3, 1'b0);
    rand_payload();
    pl[10] = SYNC;
    send_frame(xor_all() ^ 8'h01, 3, 1'b0);

    // Full-rate back-to-back frame
    rand_payload();
    send_frame(xor_all(), 0, 1'b1);

    // Timeout in payload: 6 bytes then silence -> partial word plus zero padding
    for (int k = 0; k < 6; k++) pl[k] = 8'(k + 1);
    send_payload(6, 0, 1'b0);
    begin
      int budget;
      budget = 0;
      while (!data_valid && budget < 4 * T) begin
        rx_valid = 1'b0;
        tick();
        budget++;
        if (!data_valid) begin
          check1("to_wait_err", frame_err, 1'b0);
          check1("to_wait_busy", busy, 1'b1);
        end
      end
    end
    check1("to_pad0_dv",  data_valid, 1'b1);
    check ("to_pad0",     data,       {16'h0000, pl[5], pl[4]});
    check1("to_pad0_err", frame_err,  1'b0);
    tick();
    check1("to_pad1_dv",  data_valid, 1'b1);
    check ("to_pad1",     data,       32'h0);
    check1("to_pad1_err", frame_err,  1'b0);
    tick();
    check1("to_pad2_dv",  data_valid, 1'b1);
    check ("to_pad2",     data,       32'h0);
    check1("to_pad2_err", frame_err,  1'b1);
    check1("to_busy",     busy,       1'b0);
    last_word = 32'h0;
    idle(2, 1'b0);

    // Timeout while waiting for the checksum: frame_err only, no extra words
    rand_payload();
    send_payload(NPL, 1, 1'b0);
    begin
      int budget;
      budget = 0;
      while (!frame_err && budget < 4 * T) begin
        rx_valid = 1'b0;
        tick();
        budget++;
        check1("cto_dv", data_valid, 1'b0);
        check1("cto_done", frame_done, 1'b0);
      end
    end
    check1("cto_err",  frame_err, 1'b1);
    check1("cto_busy", busy,      1'b0);
    idle(2, 1'b0);

    // Reset mid-frame: no padding afterwards, next frame clean
    rand_payload();
    send_payload(5, 1, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check1("mrst_dv",   data_valid, 1'b0);
    check ("mrst_data", data,       32'h0);
    check1("mrst_done", frame_done, 1'b0);
    check1("mrst_err",  frame_err,  1'b0);
    check1("mrst_busy", busy,       1'b0);
    last_word = 32'h0;
    idle(3 * T, 1'b0);
    rand_payload();
    send_frame(xor_all(), 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
